int_to_fp_converter: RTL and testbench
======================================

INT_TO_FP_CONVERTER -- requirements
Module: int_to_fp_converter

Interface
REQ-001 The block SHALL use one clock: clk, input, 1 bit, rising-edge clock for all state.
REQ-002 The block SHALL use reset: reset, input, 1 bit, asynchronous, active-high; asserting it forces reset state immediately, independent of clk.
REQ-003 The block SHALL have port in_valid, input, 1 bit: x is valid.
REQ-004 The block SHALL have port in_ready, output, 1 bit: block can accept x.
REQ-005 The block SHALL have port x, input, 16 bits: two's-complement signed integer.
REQ-006 The block SHALL have port out_valid, output, 1 bit: r and the flags are valid.
REQ-007 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-008 The block SHALL have port r, output, 16 bits: IEEE-754 binary16 result.
REQ-009 The block SHALL have port negative, output, 1 bit: r[15].
REQ-010 The block SHALL have port zero, output, 1 bit: x was 0.
REQ-011 The block SHALL have port inexact, output, 1 bit: nonzero bits were discarded or rounding changed the value.

Function
REQ-012 The block SHALL use FSM states IDLE, ABS, NORM, PACK, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 IDLE: when in_valid=1, the block SHALL register x and go to ABS on that edge.
REQ-014 ABS: the block SHALL form the 16-bit unsigned magnitude (0x8000 for -32768), set sign=x[15] and exp=30, then go to PACK if the magnitude is 0, else to NORM.
REQ-015 NORM: if mag[15]=1 the block SHALL go to PACK; otherwise it SHALL shift mag left 1 and decrement exp by 1; one shift per cycle.
REQ-016 PACK: the block SHALL compute mantissa=mag[14:5], guard=mag[4] and sticky=|mag[3:0], register r and the flags, and go to DONE.
REQ-017 Zero input SHALL give r=0x0000, zero=1, negative=0, inexact=0.
REQ-018 Latency from the accepting edge to out_valid high SHALL be k+3 cycles, where k is the leading-zero count of the magnitude (0..15); zero input SHALL take 2 cycles.
REQ-019 DONE: the block SHALL hold r, the flags and out_valid stable while out_ready=0, and go to IDLE on the first edge with out_ready=1.
REQ-020 The block SHALL never produce Inf, NaN, subnormal or overflow; |x| ≤ 32768 lies within binary16 range.
REQ-021 x SHALL be ignored outside IDLE; there is no input buffering.

Reset
REQ-022 On reset the block SHALL set state=IDLE, in_ready=1, out_valid=0, r=0x0000, negative=0, zero=0, inexact=0, and clear the internal mag, exp and sign registers.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no output produced; the first post-reset edge with in_valid=1 SHALL be accepted.

Configuration
REQ-024 With FP_ROUND_NEAREST_EN defined, PACK SHALL round to nearest-even: increment when guard&(sticky|mantissa[0]); a mantissa carry-out SHALL zero the mantissa and increment exp.
REQ-025 Without FP_ROUND_NEAREST_EN, PACK SHALL truncate toward zero; inexact SHALL still be set when guard|sticky.

Structure
REQ-026 Package fp_pkg SHALL hold the binary16 field widths, EXP_BIAS=15, INT_MAX_EXP=30, and the FSM state enum.
REQ-027 Rounding and field packing SHALL be a combinational sub-module fp16_round_pack (inputs sign, exp, mag, outputs r, inexact); the FSM and datapath registers SHALL live in int_to_fp_converter.

Verification
REQ-028 Scenario: x=0x0001 -> r=0x3C00, out_valid 18 cycles after accept, inexact=0.
REQ-029 Scenario: x=0xFFFF (-1) -> r=0xBC00, negative=1; x=0x8000 -> r=0xF800, latency 3.
REQ-030 Scenario: x=1000 (0x03E8) -> r=0x63D0, inexact=0, latency 9.
REQ-031 Scenario: x=0x7FFF -> r=0x7800, inexact=1 with FP_ROUND_NEAREST_EN; r=0x77FF, inexact=1 without it.
REQ-032 Scenario: x=0 -> r=0x0000, zero=1, latency 2; out_ready held 0 for 5 cycles -> r stable, in_ready=0 throughout.
REQ-033 Scenario: reset pulsed during NORM -> out_valid stays 0, in_ready=1 immediately; the next x=0x0002 -> r=0x4000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary16 field widths, exponent constants and converter FSM states.
// Consumers: int_to_fp_converter, fp16_round_pack (rounding mode set by FP_ROUND_NEAREST_EN).
package fp_pkg;

    localparam int INT_W       = 16;
    localparam int FP16_W      = 16;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MAN_W  = 10;
    localparam int EXP_BIAS    = 15;
    localparam int INT_MAX_EXP = 30;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational rounding and field packing of a normalized 16-bit magnitude into binary16.
// Macro FP_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation toward zero.
module fp16_round_pack
    import fp_pkg::*;
(
    input  logic                  sign,
    input  logic [FP16_EXP_W-1:0] exp,
    input  logic [INT_W-1:0]      mag,
    output logic [FP16_W-1:0]     r,
    output logic                  inexact
);

    logic [FP16_MAN_W-1:0] w_man;
    logic                  w_guard;
    logic                  w_sticky;
    logic [FP16_MAN_W-1:0] w_man_out;
    logic [FP16_EXP_W-1:0] w_exp_out;

    assign w_man    = mag[14:5];
    assign w_guard  = mag[4];
    assign w_sticky = |mag[3:0];

`ifdef FP_ROUND_NEAREST_EN
    logic                  w_inc;
    logic                  w_carry;
    logic [FP16_MAN_W-1:0] w_man_rnd;

    assign w_inc = w_guard & (w_sticky | w_man[0]);
    // A carry out of the mantissa leaves it all-zero and bumps the exponent;
    // the largest input (0x8000) has no guard bit, so exp cannot reach 31.
    assign {w_carry, w_man_rnd} = {1'b0, w_man} + {{FP16_MAN_W{1'b0}}, w_inc};
    assign w_man_out = w_man_rnd;
    assign w_exp_out = exp + {{(FP16_EXP_W-1){1'b0}}, w_carry};
`else
    assign w_man_out = w_man;
    assign w_exp_out = exp;
`endif

    always_comb begin
        r       = '0;
        inexact = 1'b0;
        if (mag != '0) begin
            r       = {sign, w_exp_out, w_man_out};
            inexact = w_guard | w_sticky;
        end
    end

endmodule

// File: rtl/int_to_fp_converter.sv
// Multi-cycle signed 16-bit integer to binary16 converter, one normalize shift per cycle.
// Rounding mode chosen by macro FP_ROUND_NEAREST_EN (see fp16_round_pack).
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// ABS   | form magnitude, sign and starting exponent
// NORM  | shift magnitude left until bit 15 is set
// PACK  | round, pack and register result and flags
// DONE  | out_valid high, hold result until out_ready
module int_to_fp_converter
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INT_W-1:0]  x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP16_W-1:0] r,
    output logic              negative,
    output logic              zero,
    output logic              inexact
);

    state_t                r_state;
    state_t                w_next;
    logic [INT_W-1:0]      r_x;
    logic [INT_W-1:0]      r_mag;
    logic [FP16_EXP_W-1:0] r_exp;
    logic                  r_sign;
    logic [FP16_W-1:0]     r_res;
    logic                  r_neg;
    logic                  r_zero;
    logic                  r_inexact;

    logic [INT_W-1:0]      w_mag_abs;
    logic [FP16_W-1:0]     w_r;
    logic                  w_inexact;

    // -32768 negates to itself, which is exactly the unsigned magnitude 0x8000.
    assign w_mag_abs = r_x[INT_W-1] ? (~r_x + 16'd1) : r_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ABS;
            end
            ABS:  w_next = (w_mag_abs == '0) ? PACK : NORM;
            NORM: if (r_mag[INT_W-1]) w_next = PACK;
            PACK: w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x       <= '0;
            r_mag     <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_res     <= '0;
            r_neg     <= 1'b0;
            r_zero    <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) r_x <= x;
                ABS: begin
                    r_mag  <= w_mag_abs;
                    r_sign <= r_x[INT_W-1];
                    r_exp  <= FP16_EXP_W'(INT_MAX_EXP);
                end
                NORM: begin
                    if (!r_mag[INT_W-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 5'd1;
                    end
                end
                PACK: begin
                    r_res     <= w_r;
                    r_neg     <= w_r[FP16_W-1];
                    r_zero    <= (r_mag == '0);
                    r_inexact <= w_inexact;
                end
                default: ;
            endcase
        end
    end

    fp16_round_pack u_round_pack (
        .sign    (r_sign),
        .exp     (r_exp),
        .mag     (r_mag),
        .r       (w_r),
        .inexact (w_inexact)
    );

    assign r        = r_res;
    assign negative = r_neg;
    assign zero     = r_zero;
    assign inexact  = r_inexact;

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Directed self-checking bench for int_to_fp_converter with hand-computed binary16 results.
// Expectation for 0x7FFF follows FP_ROUND_NEAREST_EN.
module tb_int_to_fp_converter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        negative;
    logic        zero;
    logic        inexact;

    int n_tests = 0;
    int n_fail  = 0;

    int_to_fp_converter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .negative  (negative),
        .zero      (zero),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp_v);
        end
    endtask

    // Accept xv, measure latency, check result; optionally stall the consumer for hold cycles.
    task automatic convert(input string tag, input logic [15:0] xv, input int lat,
                           input logic [15:0] er, input logic en, input logic ez,
                           input logic ei, input int hold);
        int cyc;
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 16'(in_ready), 16'h1);
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = 16'hA5A5;
        chk({tag, ".in_ready_busy"}, 16'(in_ready), 16'h0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".latency"}, 16'(cyc), 16'(lat));
        chk({tag, ".r"}, r, er);
        chk({tag, ".negative"}, 16'(negative), 16'(en));
        chk({tag, ".zero"}, 16'(zero), 16'(ez));
        chk({tag, ".inexact"}, 16'(inexact), 16'(ei));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x        = 16'h1234;
            @(posedge clk);
            #1;
            chk({tag, ".hold_r"}, r, er);
            chk({tag, ".hold_out_valid"}, 16'(out_valid), 16'h1);
            chk({tag, ".hold_in_ready"}, 16'(in_ready), 16'h0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".released_out_valid"}, 16'(out_valid), 16'h0);
        chk({tag, ".released_in_ready"}, 16'(in_ready), 16'h1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'h0000;
        #1;
        chk("reset.in_ready", 16'(in_ready), 16'h1);
        chk("reset.out_valid", 16'(out_valid), 16'h0);
        chk("reset.r", r, 16'h0000);
        chk("reset.flags", {13'd0, negative, zero, inexact}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        convert("x_1",     16'h0001, 18, 16'h3C00, 1'b0, 1'b0, 1'b0, 0);
        convert("x_m1",    16'hFFFF, 18, 16'hBC00, 1'b1, 1'b0, 1'b0, 0);
        convert("x_m32768",16'h8000,  3, 16'hF800, 1'b1, 1'b0, 1'b0, 0);
        convert("x_1000",  16'h03E8,  9, 16'h63D0, 1'b0, 1'b0, 1'b0, 0);
`ifdef FP_ROUND_NEAREST_EN
        convert("x_7fff",  16'h7FFF,  4, 16'h7800, 1'b0, 1'b0, 1'b1, 0);
`else
        convert("x_7fff",  16'h7FFF,  4, 16'h77FF, 1'b0, 1'b0, 1'b1, 0);
`endif
        // -1000: same magnitude as 1000, sign bit set
        convert("x_m1000", 16'hFC18,  9, 16'hE3D0, 1'b1, 1'b0, 1'b0, 0);
        // 0x0421: exact 11 significant bits, guard/sticky zero
        convert("x_0421",  16'h0421,  8, 16'h6421, 1'b0, 1'b0, 1'b0, 0);
        convert("x_0",     16'h0000,  2, 16'h0000, 1'b0, 1'b1, 1'b0, 5);

        // Abort a long conversion in NORM with an asynchronous reset pulse.
        @(negedge clk);
        x        = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort.in_ready", 16'(in_ready), 16'h1);
        chk("abort.out_valid", 16'(out_valid), 16'h0);
        chk("abort.r", r, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("abort.no_output", 16'(out_valid), 16'h0);
        end
        convert("post_reset_x2", 16'h0002, 17, 16'h4000, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
